npu_kernel_loader: RTL and testbench

- Fetches kernel weights from the NPU weight memory and writes them into the kernel register file.
- Sits directly upstream of the kernel register file and convolution datapath inside npt_top.
- Triggered by the top-level start pulse; its done pulse is the top-level kernel-loading-done indication.
- Exports its FSM state and the current kernel register write address for monitoring.

---
 rtl/npu_kernel_loader_if.sv | 25 ++
 rtl/npu_kernel_loader.sv | 149 ++++++++++++++
 tb/tb_npu_kernel_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_kernel_loader_if.sv
// Bus bundle between the kernel loader, the weight memory read port
// and the kernel register file write port.
interface npu_kernel_loader_if #(
  parameter int DATA_W  = 8,
  parameter int KADDR_W = 6,
  parameter int MEM_AW  = 10
);
  logic               mem_rd_en;
  logic [MEM_AW-1:0]  mem_addr;
  logic               mem_rd_valid;
  logic [DATA_W-1:0]  mem_rd_data;
  logic               kreg_wr_en;
  logic [KADDR_W-1:0] kreg_wr_addr;
  logic [DATA_W-1:0]  kreg_wr_data;

  modport master (
    output mem_rd_en, mem_addr, kreg_wr_en, kreg_wr_addr, kreg_wr_data,
    input  mem_rd_valid, mem_rd_data
  );

  modport slave (
    input  mem_rd_en, mem_addr, kreg_wr_en, kreg_wr_addr, kreg_wr_data,
    output mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/npu_kernel_loader.sv
// Kernel weight loader: reads up to 64 words from weight memory, one read outstanding at a
// time, and writes them to kernel register file addresses 0..N-1. Sticky error on read timeout.
module npu_kernel_loader #(
  parameter int DATA_W  = 8,
  parameter int KADDR_W = 6,
  parameter int MEM_AW  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [MEM_AW-1:0]   i_base_addr,
  input  logic [KADDR_W:0]    i_num_words,
  npu_kernel_loader_if.master bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [2:0]          o_state
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  TMO_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [KADDR_W:0]  MAX_WORDS = {1'b1, {KADDR_W{1'b0}}};
  localparam logic [KADDR_W:0]  IDX_ONE   = {{KADDR_W{1'b0}}, 1'b1};

  logic [2:0]         state_q, state_d;
  logic [MEM_AW-1:0]  base_q, base_d;
  logic [KADDR_W:0]   count_q, count_d;
  logic [KADDR_W-1:0] index_q, index_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               error_q, error_d;
  logic [MEM_AW-1:0]  mem_addr_q, mem_addr_d;
  logic [KADDR_W-1:0] kaddr_q, kaddr_d;

  logic [KADDR_W:0]   index_inc;
  logic               last_word;
  logic               timed_out;

  assign index_inc = {1'b0, index_q} + IDX_ONE;
  assign last_word = (index_inc == count_q);
  assign timed_out = !bus.mem_rd_valid && (tmo_q == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      base_q     <= '0;
      count_q    <= '0;
      index_q    <= '0;
      tmo_q      <= '0;
      data_q     <= '0;
      error_q    <= 1'b0;
      mem_addr_q <= '0;
      kaddr_q    <= '0;
    end else begin
      base_q     <= base_d;
      count_q    <= count_d;
      index_q    <= index_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      error_q    <= error_d;
      mem_addr_q <= mem_addr_d;
      kaddr_q    <= kaddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = (i_num_words == '0) ? S_DONE : S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_rd_valid) state_d = S_WRITE;
        else if (timed_out)   state_d = S_DONE;
      end
      S_WRITE: state_d = last_word ? S_DONE : S_REQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The memory address register is loaded whenever the FSM is about to enter REQ,
  // so it is already valid during the single-cycle read strobe.
  always_comb begin
    base_d     = base_q;
    count_d    = count_q;
    index_d    = index_q;
    tmo_d      = tmo_q;
    data_d     = data_q;
    error_d    = error_q;
    mem_addr_d = mem_addr_q;
    kaddr_d    = kaddr_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d     = i_base_addr;
          count_d    = (i_num_words > MAX_WORDS) ? MAX_WORDS : i_num_words;
          index_d    = '0;
          tmo_d      = '0;
          error_d    = 1'b0;
          mem_addr_d = i_base_addr;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_ONE;
        if (bus.mem_rd_valid) begin
          data_d  = bus.mem_rd_data;
          kaddr_d = index_q;
        end else if (timed_out) begin
          error_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (!last_word) begin
          index_d    = index_inc[KADDR_W-1:0];
          tmo_d      = '0;
          mem_addr_d = base_q + MEM_AW'(index_inc);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    o_busy         = (state_q != S_IDLE);
    o_done         = (state_q == S_DONE);
    bus.mem_rd_en  = (state_q == S_REQ);
    bus.kreg_wr_en = (state_q == S_WRITE);
  end

  assign bus.mem_addr     = mem_addr_q;
  assign bus.kreg_wr_addr = kaddr_q;
  assign bus.kreg_wr_data = data_q;
  assign o_error          = error_q;
  assign o_state          = state_q;
endmodule

// File: tb/tb_npu_kernel_loader.sv
// Self-checking bench for npu_kernel_loader: behavioural weight memory with configurable
// latency, stray valids and withheld responses, compared against a per-load reference model.
module tb_npu_kernel_loader;
  localparam int DATA_W  = 8;
  localparam int KADDR_W = 6;
  localparam int MEM_AW  = 10;
  localparam int TIMEOUT = 16;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       start     = 1'b0;
  logic [9:0] base_addr = '0;
  logic [6:0] num_words = '0;
  logic       busy, done, error;
  logic [2:0] state;

  npu_kernel_loader_if #(.DATA_W(DATA_W), .KADDR_W(KADDR_W), .MEM_AW(MEM_AW)) bus ();

  npu_kernel_loader #(.DATA_W(DATA_W), .KADDR_W(KADDR_W), .MEM_AW(MEM_AW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_num_words (num_words),
    .bus         (bus),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Weight memory model and bus monitor (all sampled/driven on the falling edge)
  logic [7:0] mem_tbl [1024];
  int         mem_lat      = 1;
  bit         mem_stray    = 1'b0;
  int         mem_withhold = -1;
  bit         pend         = 1'b0;
  int         pend_cnt     = 0;
  logic [9:0] pend_addr    = '0;

  logic [9:0] rd_log   [$];
  logic [5:0] wr_a_log [$];
  logic [7:0] wr_d_log [$];
  int         done_log [$];

  always @(negedge clk) begin
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = 8'h00;
    if (!rst_n) pend = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = mem_tbl[pend_addr];
        pend = 1'b0;
      end
    end
    if (bus.mem_rd_en === 1'b1) begin
      if (rd_log.size() != mem_withhold) begin
        pend      = 1'b1;
        pend_cnt  = mem_lat;
        pend_addr = bus.mem_addr;
      end
      rd_log.push_back(bus.mem_addr);
      if (mem_stray) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = ~mem_tbl[bus.mem_addr];
      end
    end
    if (bus.kreg_wr_en === 1'b1) begin
      wr_a_log.push_back(bus.kreg_wr_addr);
      wr_d_log.push_back(bus.kreg_wr_data);
      if (mem_stray) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 8'hA5;
      end
    end
    if (done === 1'b1) done_log.push_back(cyc);
  end

  // Reference model: what one load must produce, from the loader's rules alone
  logic [9:0] exp_rd [$];
  logic [5:0] exp_wa [$];
  logic [7:0] exp_wd [$];
  int         exp_c;
  bit         exp_err;

  task automatic model_load(input logic [9:0] base, input int num, input int lat, input int wh);
    int n;
    int nw;
    n       = (num > 64) ? 64 : num;
    exp_err = (wh >= 0) && (wh < n);
    nw      = exp_err ? wh : n;
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    for (int i = 0; i < nw; i++) begin
      exp_rd.push_back(base + 10'(i));
      exp_wa.push_back(6'(i));
      exp_wd.push_back(mem_tbl[base + 10'(i)]);
    end
    if (exp_err) exp_rd.push_back(base + 10'(wh));
    exp_c = exp_err ? wh * (lat + 2) + TIMEOUT + 2 : n * (lat + 2) + 1;
  endtask

  task automatic run_load(input logic [9:0] base, input logic [6:0] num, input int lat, input bit stray,
                          input int wh, input int mid_at, input bit in_done,
                          output int s0, output int r0, output int w0, output int d0);
    bit fin;
    fin = 1'b0;
    r0  = rd_log.size();
    w0  = wr_a_log.size();
    d0  = done_log.size();
    mem_lat      = lat;
    mem_stray    = stray;
    mem_withhold = (wh < 0) ? -1 : r0 + wh;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_words = num; s0 = cyc;
    for (int i = 0; i < 1000 && !fin; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == mid_at) begin
        start     = 1'b1;
        base_addr = 10'($urandom);
        num_words = 7'($urandom_range(1, 64));
      end
      if (done === 1'b1) begin
        fin   = 1'b1;
        start = in_done;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    mem_withhold = -1;
    mem_stray    = 1'b0;
    $display("load base=%03h num=%0d lat=%0d stray=%0d reads=%0d writes=%0d dones=%0d err=%0d",
             base, num, lat, stray, rd_log.size() - r0, wr_a_log.size() - w0,
             done_log.size() - d0, error);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, error, state, bus.mem_rd_en, bus.kreg_wr_en} !== 9'd0 ||
        bus.mem_addr !== 10'd0 || bus.kreg_wr_addr !== 6'd0 || bus.kreg_wr_data !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b state=%0d rd=%b wr=%b maddr=%h kaddr=%h kdata=%h want all 0",
               busy, done, error, state, bus.mem_rd_en, bus.kreg_wr_en, bus.mem_addr,
               bus.kreg_wr_addr, bus.kreg_wr_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got state=%0d busy=%b want state=0 busy=0", state, busy);
    end
  endtask

  task automatic test_full_load();
    int s0, r0, w0, d0;
    for (int a = 0; a < 1024; a++) mem_tbl[a] = 8'(a);
    model_load(10'h000, 64, 1, -1);
    run_load(10'h000, 7'd64, 1, 1'b0, -1, -1, 1'b0, s0, r0, w0, d0);
    total++;
    if (wr_a_log.size() - w0 != exp_wa.size() || rd_log.size() - r0 != exp_rd.size()) begin
      bad++;
      $display("FAIL full_load_count got writes=%0d reads=%0d want %0d/%0d",
               wr_a_log.size() - w0, rd_log.size() - r0, exp_wa.size(), exp_rd.size());
    end
    for (int k = 0; k < exp_wa.size(); k++) begin
      total++;
      if (w0 + k >= wr_a_log.size() || wr_a_log[w0+k] !== exp_wa[k] || wr_d_log[w0+k] !== exp_wd[k]) begin
        bad++;
        $display("FAIL full_load_write[%0d] want addr=%0d data=%h", k, exp_wa[k], exp_wd[k]);
      end
    end
    total++;
    if (done_log.size() - d0 != 1 || done_log[d0] - s0 != exp_c) begin
      bad++;
      $display("FAIL full_load_done got pulses=%0d want 1 at cycle %0d", done_log.size() - d0, exp_c);
    end
    total++;
    if (error !== 1'b0) begin
      bad++;
      $display("FAIL full_load_error got=%b want=0", error);
    end
  endtask

  task automatic test_addr_wrap();
    int s0, r0, w0, d0;
    for (int a = 0; a < 1024; a++) mem_tbl[a] = 8'($urandom);
    model_load(10'h3FE, 4, 1, -1);
    run_load(10'h3FE, 7'd4, 1, 1'b0, -1, -1, 1'b0, s0, r0, w0, d0);
    for (int k = 0; k < exp_rd.size(); k++) begin
      total++;
      if (r0 + k >= rd_log.size() || rd_log[r0+k] !== exp_rd[k]) begin
        bad++;
        $display("FAIL wrap_read[%0d] want addr=%03h", k, exp_rd[k]);
      end
    end
    for (int k = 0; k < exp_wa.size(); k++) begin
      total++;
      if (w0 + k >= wr_a_log.size() || wr_a_log[w0+k] !== exp_wa[k] || wr_d_log[w0+k] !== exp_wd[k]) begin
        bad++;
        $display("FAIL wrap_write[%0d] want addr=%0d data=%h", k, exp_wa[k], exp_wd[k]);
      end
    end
    total++;
    if (rd_log.size() - r0 != 4 || wr_a_log.size() - w0 != 4) begin
      bad++;
      $display("FAIL wrap_count got reads=%0d writes=%0d want 4/4", rd_log.size() - r0, wr_a_log.size() - w0);
    end
  endtask

  task automatic test_zero_count();
    int s0, r0, w0, d0;
    model_load(10'h123, 0, 1, -1);
    run_load(10'h123, 7'd0, 1, 1'b0, -1, -1, 1'b0, s0, r0, w0, d0);
    total++;
    if (rd_log.size() != r0 || wr_a_log.size() != w0) begin
      bad++;
      $display("FAIL zero_strobes got reads=%0d writes=%0d want 0/0", rd_log.size() - r0, wr_a_log.size() - w0);
    end
    total++;
    if (done_log.size() - d0 != 1 || done_log[d0] - s0 != exp_c) begin
      bad++;
      $display("FAIL zero_done got pulses=%0d want 1 at cycle %0d", done_log.size() - d0, exp_c);
    end
  endtask

  task automatic test_timeout();
    int s0, r0, w0, d0;
    for (int a = 0; a < 1024; a++) mem_tbl[a] = 8'($urandom);
    model_load(10'h050, 8, 1, 2);
    run_load(10'h050, 7'd8, 1, 1'b0, 2, -1, 1'b0, s0, r0, w0, d0);
    total++;
    if (error !== 1'b1) begin
      bad++;
      $display("FAIL timeout_error got=%b want=1", error);
    end
    total++;
    if (done_log.size() - d0 != 1 || done_log[d0] - s0 != exp_c) begin
      bad++;
      $display("FAIL timeout_done got pulses=%0d want 1 at cycle %0d", done_log.size() - d0, exp_c);
    end
    total++;
    if (wr_a_log.size() - w0 != exp_wa.size() || rd_log.size() - r0 != exp_rd.size()) begin
      bad++;
      $display("FAIL timeout_count got writes=%0d reads=%0d want %0d/%0d",
               wr_a_log.size() - w0, rd_log.size() - r0, exp_wa.size(), exp_rd.size());
    end
    for (int k = 0; k < exp_wa.size(); k++) begin
      total++;
      if (w0 + k >= wr_a_log.size() || wr_a_log[w0+k] !== exp_wa[k] || wr_d_log[w0+k] !== exp_wd[k]) begin
        bad++;
        $display("FAIL timeout_write[%0d] want addr=%0d data=%h", k, exp_wa[k], exp_wd[k]);
      end
    end
    model_load(10'h200, 1, 1, -1);
    run_load(10'h200, 7'd1, 1, 1'b0, -1, -1, 1'b0, s0, r0, w0, d0);
    total++;
    if (error !== 1'b0 || wr_a_log.size() - w0 != 1) begin
      bad++;
      $display("FAIL timeout_clear got err=%b writes=%0d want err=0 writes=1", error, wr_a_log.size() - w0);
    end
  endtask

  task automatic test_start_busy();
    int s0, r0, w0, d0;
    logic [9:0] base;
    for (int a = 0; a < 1024; a++) mem_tbl[a] = 8'($urandom);
    base = 10'($urandom);
    model_load(base, 10, 5, -1);
    run_load(base, 7'd10, 5, 1'b1, -1, 7, 1'b1, s0, r0, w0, d0);
    total++;
    if (rd_log.size() - r0 != exp_rd.size() || wr_a_log.size() - w0 != exp_wa.size()) begin
      bad++;
      $display("FAIL busy_count got reads=%0d writes=%0d want %0d/%0d",
               rd_log.size() - r0, wr_a_log.size() - w0, exp_rd.size(), exp_wa.size());
    end
    for (int k = 0; k < exp_wa.size(); k++) begin
      total++;
      if (w0 + k >= wr_a_log.size() || wr_a_log[w0+k] !== exp_wa[k] || wr_d_log[w0+k] !== exp_wd[k] ||
          r0 + k >= rd_log.size() || rd_log[r0+k] !== exp_rd[k]) begin
        bad++;
        $display("FAIL busy_word[%0d] want raddr=%03h waddr=%0d data=%h", k, exp_rd[k], exp_wa[k], exp_wd[k]);
      end
    end
    total++;
    if (done_log.size() - d0 != 1 || done_log[d0] - s0 != exp_c || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_done got pulses=%0d busy=%b want 1 pulse at cycle %0d then idle",
               done_log.size() - d0, busy, exp_c);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int s0, r0, w0, d0;
      logic [9:0] base;
      int num, lat, wh;
      bit stray;
      base  = 10'($urandom);
      num   = $urandom_range(0, 100);
      lat   = $urandom_range(1, 5);
      stray = 1'($urandom);
      wh    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, num) : -1;
      for (int a = 0; a < 1024; a++) mem_tbl[a] = 8'($urandom);
      model_load(base, num, lat, wh);
      run_load(base, 7'(num), lat, stray, wh, -1, 1'b0, s0, r0, w0, d0);
      total++;
      if (rd_log.size() - r0 != exp_rd.size() || wr_a_log.size() - w0 != exp_wa.size()) begin
        bad++;
        $display("FAIL rand%0d_count got reads=%0d writes=%0d want %0d/%0d", it,
                 rd_log.size() - r0, wr_a_log.size() - w0, exp_rd.size(), exp_wa.size());
      end
      for (int k = 0; k < exp_wa.size(); k++) begin
        total++;
        if (w0 + k >= wr_a_log.size() || wr_a_log[w0+k] !== exp_wa[k] || wr_d_log[w0+k] !== exp_wd[k] ||
            r0 + k >= rd_log.size() || rd_log[r0+k] !== exp_rd[k]) begin
          bad++;
          $display("FAIL rand%0d_word[%0d] want raddr=%03h waddr=%0d data=%h", it, k,
                   exp_rd[k], exp_wa[k], exp_wd[k]);
        end
      end
      total++;
      if (done_log.size() - d0 != 1 || done_log[d0] - s0 != exp_c || error !== exp_err) begin
        bad++;
        $display("FAIL rand%0d_done got pulses=%0d err=%b want 1 pulse at cycle %0d err=%b", it,
                 done_log.size() - d0, error, exp_c, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    int w0, r1, w1;
    for (int a = 0; a < 1024; a++) mem_tbl[a] = 8'($urandom);
    mem_lat = 1;
    w0 = wr_a_log.size();
    @(negedge clk);
    start = 1'b1; base_addr = 10'h100; num_words = 7'd64;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && (wr_a_log.size() - w0) < 40; i++) begin
      @(negedge clk);
      #1;
    end
    total++;
    if (wr_a_log.size() - w0 != 40) begin
      bad++;
      $display("FAIL rst_mid_reach got writes=%0d want 40", wr_a_log.size() - w0);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || bus.kreg_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL rst_mid_async got busy=%b wr=%b rd=%b state=%0d want 0/0/0/0",
               busy, bus.kreg_wr_en, bus.mem_rd_en, state);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r1 = rd_log.size();
    w1 = wr_a_log.size();
    repeat (20) @(negedge clk);
    #1;
    total++;
    if (rd_log.size() != r1 || wr_a_log.size() != w1 || state !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_after got reads=%0d writes=%0d state=%0d busy=%b want 0/0/0/0",
               rd_log.size() - r1, wr_a_log.size() - w1, state, busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_addr_wrap();
    test_zero_count();
    test_timeout();
    test_start_busy();
    test_random();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
